quad_enc_filter: RTL and testbench

Input conditioning stage placed directly upstream of the rotary encoder position counter. It synchronises the raw quadrature A/B pins and debounces each channel independently. It then emits clean A/B levels plus one-cycle step/direction pulses. Illegal double-bit transitions are flagged on a sticky error output.

---
 rtl/quad_enc_filter.sv | 147 ++++++++++++++
 tb/tb_quad_enc_filter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_enc_filter.sv
// Quadrature encoder input conditioner: per-channel synchroniser and debouncer,
// followed by a registered step/direction decoder with a sticky illegal-transition flag.
module quad_enc_filter #(
    parameter int unsigned STAGES    = 2,
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned CNTW      = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enc_a,
    input  logic i_enc_b,
    input  logic i_err_clr,
    output logic o_enc_a,
    output logic o_enc_b,
    output logic o_step,
    output logic o_dir,
    output logic o_err,
    output logic o_ready
);

    localparam logic [CNTW-1:0] DbLast   = CNTW'(DB_CYCLES - 1);
    localparam logic [CNTW-1:0] InitLast = CNTW'(STAGES + DB_CYCLES - 1);

    typedef enum logic {
        StInit,
        StRun
    } state_t;

    state_t          r_state;
    logic [CNTW-1:0] r_init_cnt;
    logic            r_ready;

    logic [STAGES-1:0] r_sync_a;
    logic [STAGES-1:0] r_sync_b;

    // Bit 1 carries channel A, bit 0 carries channel B throughout.
    logic [1:0]      w_s;
    logic [1:0]      r_filt;
    logic [1:0]      r_prev;
    logic [1:0]      w_filt_next;
    logic [1:0]      w_chg;
    logic [CNTW-1:0] r_cnt      [2];
    logic [CNTW-1:0] w_cnt_next [2];

    logic r_step;
    logic r_dir;
    logic r_err;

    assign w_s   = {r_sync_a[STAGES-1], r_sync_b[STAGES-1]};
    assign w_chg = r_filt ^ r_prev;

    // Synchroniser chains for the asynchronous encoder pins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[STAGES-2:0], i_enc_a};
            r_sync_b <= {r_sync_b[STAGES-2:0], i_enc_b};
        end
    end

    // Debounce next-state: a level is accepted only after DB_CYCLES consecutive mismatches.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_filt_next[i] = r_filt[i];
            w_cnt_next[i]  = '0;
            if (w_s[i] != r_filt[i]) begin
                if (r_cnt[i] == DbLast) begin
                    w_filt_next[i] = w_s[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // INIT/RUN sequencing: INIT tracks the synced pins directly until the pipeline has filled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StInit;
            r_init_cnt <= '0;
            r_ready    <= 1'b0;
            r_filt     <= '0;
            r_prev     <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            unique case (r_state)
                StInit: begin
                    // prev follows the same value so RUN starts with no phantom step.
                    r_filt <= w_s;
                    r_prev <= w_s;
                    for (int i = 0; i < 2; i++) begin
                        r_cnt[i] <= '0;
                    end
                    if (r_init_cnt == InitLast) begin
                        r_state    <= StRun;
                        r_init_cnt <= '0;
                        r_ready    <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                StRun: begin
                    r_filt  <= w_filt_next;
                    r_prev  <= r_filt;
                    r_ready <= 1'b1;
                    for (int i = 0; i < 2; i++) begin
                        r_cnt[i] <= w_cnt_next[i];
                    end
                end
            endcase
        end
    end

    // Step/direction decode and sticky error; a set event beats a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step <= 1'b0;
            r_dir  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            r_dir  <= 1'b0;
            if ((r_state == StRun) && (w_chg == 2'b11)) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
            if ((r_state == StRun) && ((w_chg == 2'b01) || (w_chg == 2'b10))) begin
                r_step <= 1'b1;
                // Up order 00->01->11->10->00 reduces to prev_a xor cur_b.
                r_dir  <= r_prev[1] ^ r_filt[0];
            end
        end
    end

    assign o_enc_a = r_filt[1];
    assign o_enc_b = r_filt[0];
    assign o_step  = r_step;
    assign o_dir   = r_dir;
    assign o_err   = r_err;
    assign o_ready = r_ready;

endmodule

// File: tb/tb_quad_enc_filter.sv
// Scoreboard bench for quad_enc_filter: a reference model predicts step events and
// levels from the pin history; a monitor compares DUT outputs each cycle.
module tb_quad_enc_filter;

    localparam int STAGES = 2;
    localparam int DB     = 4;
    localparam int CNTW   = 10;
    localparam int LAT    = STAGES + DB;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic err_clr = 1'b0;
    logic o_enc_a, o_enc_b, o_step, o_dir, o_err, o_ready;

    int total = 0;
    int bad = 0;

    quad_enc_filter #(
        .STAGES   (STAGES),
        .DB_CYCLES(DB),
        .CNTW     (CNTW)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_enc_a  (enc_a),
        .i_enc_b  (enc_b),
        .i_err_clr(err_clr),
        .o_enc_a  (o_enc_a),
        .o_enc_b  (o_enc_b),
        .o_step   (o_step),
        .o_dir    (o_dir),
        .o_err    (o_err),
        .o_ready  (o_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Position around the quadrature cycle; +1 is an up step, +3 down, +2 illegal.
    function automatic int pos(input bit [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    typedef struct {
        int due;
        bit dir;
    } ev_t;

    ev_t sbq[$];

    // Reference model state.
    bit [1:0] hist[$];
    bit [1:0] m_s, m_filt, s_old, old_filt;
    int       m_mis[2];
    int       m_e, m_init, d;
    bit       m_run, m_err, m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            sbq.delete();
            m_s = '0; m_filt = '0; m_mis[0] = 0; m_mis[1] = 0;
            m_e = 0; m_init = 0; m_run = 0; m_err = 0; m_pend = 0;
        end else begin
            m_e++;
            s_old = m_s;
            if (m_pend) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            m_pend = 1'b0;
            if (!m_run) begin
                m_filt = s_old;
                m_init++;
                if (m_init == LAT) m_run = 1'b1;
            end else begin
                old_filt = m_filt;
                for (int ch = 0; ch < 2; ch++) begin
                    // Level accepted after DB consecutive edges of disagreement.
                    if (s_old[ch] != m_filt[ch]) begin
                        m_mis[ch]++;
                        if (m_mis[ch] == DB) begin
                            m_filt[ch] = s_old[ch];
                            m_mis[ch] = 0;
                        end
                    end else begin
                        m_mis[ch] = 0;
                    end
                end
                if (m_filt != old_filt) begin
                    d = (pos(m_filt) - pos(old_filt) + 4) % 4;
                    if (d == 2) m_pend = 1'b1;
                    else sbq.push_back('{m_e + 1, d == 1});
                end
            end
            hist.push_back({enc_a, enc_b});
            if (hist.size() > STAGES) void'(hist.pop_front());
            m_s = (hist.size() == STAGES) ? hist[0] : 2'b00;
        end
    end

    // Monitor: compare levels every cycle, pop the scoreboard on step pulses.
    int n_step = 0;
    int n_up = 0;
    int n_arise = 0;
    logic mon_prev_a = 1'b0;

    always @(negedge clk) begin
        chk_bit("ready", o_ready, m_run);
        chk_bit("enc_a", o_enc_a, m_filt[1]);
        chk_bit("enc_b", o_enc_b, m_filt[0]);
        chk_bit("err", o_err, m_err);
        if (o_enc_a && !mon_prev_a) n_arise++;
        mon_prev_a = o_enc_a;
        if (o_step) begin
            n_step++;
            if (o_dir) n_up++;
            if (sbq.size() > 0 && sbq[0].due == m_e) begin
                chk_bit("step_dir", o_dir, sbq[0].dir);
                void'(sbq.pop_front());
            end else begin
                chk_bit("unexpected_step", o_step, 1'b0);
            end
        end else begin
            chk_bit("dir_idle", o_dir, 1'b0);
            if (sbq.size() > 0 && sbq[0].due <= m_e) begin
                chk_bit("missing_step", o_step, 1'b1);
                void'(sbq.pop_front());
            end
        end
    end

    int lat, s0, u0, r0;

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a new AB, measure pin-to-output latency, then complete a 20-cycle hold.
    task automatic step_to(input bit a, input bit b, input string nm);
        enc_a = a;
        enc_b = b;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while ({o_enc_a, o_enc_b} != {a, b} && lat < 30);
        chk_int(nm, lat, LAT);
        if (lat < 20) hold(20 - lat);
    endtask

    task automatic wait_ready(input string nm, input int exp);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_ready && lat < 30);
        chk_int(nm, lat, exp);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        hold(3);
        rst_n = 1'b1;
        s0 = n_step;
        wait_ready("ready_latency", LAT);
        hold(5);
        chk_int("no_step_at_init", n_step - s0, 0);
        chk_bit("no_err_at_init", o_err, 1'b0);

        // Up sequence.
        s0 = n_step; u0 = n_up;
        step_to(0, 1, "lat_up1");
        step_to(1, 1, "lat_up2");
        step_to(1, 0, "lat_up3");
        step_to(0, 0, "lat_up4");
        chk_int("up_steps", n_step - s0, 4);
        chk_int("up_dirs", n_up - u0, 4);

        // Down sequence.
        s0 = n_step; u0 = n_up;
        step_to(1, 0, "lat_dn1");
        step_to(1, 1, "lat_dn2");
        step_to(0, 1, "lat_dn3");
        step_to(0, 0, "lat_dn4");
        chk_int("down_steps", n_step - s0, 4);
        chk_int("down_dirs", n_up - u0, 0);

        // Bounce on A: 1, 2, 3 cycle glitches, then a clean high.
        s0 = n_step; r0 = n_arise;
        enc_a = 1; hold(1); enc_a = 0; hold(1);
        enc_a = 1; hold(2); enc_a = 0; hold(1);
        enc_a = 1; hold(3); enc_a = 0; hold(1);
        chk_bit("bounce_filtered", o_enc_a, 1'b0);
        enc_a = 1; hold(20);
        chk_int("bounce_rises", n_arise - r0, 1);
        chk_int("bounce_steps", n_step - s0, 1);
        step_to(0, 0, "lat_bounce_back");

        // Double-bit transitions and the sticky error.
        s0 = n_step;
        enc_a = 1; enc_b = 1; hold(20);
        chk_bit("err_set", o_err, 1'b1);
        hold(20);
        chk_bit("err_sticky", o_err, 1'b1);
        err_clr = 1; hold(1); err_clr = 0;
        chk_bit("err_cleared", o_err, 1'b0);
        enc_a = 0; enc_b = 0; hold(LAT);
        err_clr = 1; hold(1); err_clr = 0;
        chk_bit("err_set_beats_clr", o_err, 1'b1);
        hold(14);
        chk_int("err_no_steps", n_step - s0, 0);
        err_clr = 1; hold(1); err_clr = 0;

        // Randomised pins and clears.
        for (int seg = 0; seg < 40; seg++) begin
            {enc_a, enc_b} = 2'($urandom);
            repeat ($urandom_range(1, 10)) begin
                err_clr = ($urandom_range(0, 15) == 0);
                @(negedge clk);
            end
        end
        err_clr = 0;
        enc_a = 0; enc_b = 0; hold(20);
        enc_b = 1; hold(20);

        // Reset in the middle of a debounce count.
        enc_a = 1; hold(4);
        #2 rst_n = 1'b0;
        #1;
        chk_bit("rst_enc_a", o_enc_a, 1'b0);
        chk_bit("rst_enc_b", o_enc_b, 1'b0);
        chk_bit("rst_step", o_step, 1'b0);
        chk_bit("rst_dir", o_dir, 1'b0);
        chk_bit("rst_err", o_err, 1'b0);
        chk_bit("rst_ready", o_ready, 1'b0);
        hold(3);
        enc_a = 1; enc_b = 1;
        rst_n = 1'b1;
        s0 = n_step;
        hold(3);
        chk_bit("init_enc_a", o_enc_a, 1'b1);
        chk_bit("init_enc_b", o_enc_b, 1'b1);
        chk_bit("init_not_ready", o_ready, 1'b0);
        wait_ready("ready_after_rst", LAT - 3);
        hold(20);
        chk_int("no_step_after_rst", n_step - s0, 0);
        chk_bit("no_err_after_rst", o_err, 1'b0);
        chk_int("sb_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
